// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// aluPkg
// Shared types for the ID/EX pipeline stage:
//   aluop_t       - ALU opcode encoding carried on id_op / ex_op
//   stage_state_t - hazard FSM states (RUN, BUBBLE)
//   fwd_sel_t     - operand source select (register file, EX/MEM, MEM/WB)
// Also provides fwdSelect(), which picks the operand source for one
// source register index.
// ---------------------------------------------------------------------------
package aluPkg;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10
  } aluop_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } stage_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Longest run of consecutive bubbles the non-forwarding build inserts
  // for a single instruction; by then the producer has reached the
  // register file.
  localparam logic [1:0] MAX_RAW_BUBBLES = 2'd3;

  // EX/MEM wins over MEM/WB because it holds the younger write.
  // Register 0 is hard-wired, so it never forwards.
  function automatic fwd_sel_t fwdSelect(input logic [4:0] rs,
                                         input logic [4:0] memRd,
                                         input logic       memWbEn,
                                         input logic [4:0] wbRd,
                                         input logic       wbWbEn);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (memWbEn && (memRd == rs)) begin
        sel = FWD_MEM;
      end else if (wbWbEn && (wbRd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Decides whether the ID/EX stage may accept the instruction in ID this
// cycle, and owns the RUN/BUBBLE state machine.
// Build option: ID_EX_FWD_EN
//   defined   - only load-use hazards stall, for exactly one extra cycle
//   undefined - any RAW match against EX, MEM or WB stalls, at most
//               MAX_RAW_BUBBLES bubbles in a row
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             branch redirect, returns FSM to RUN
//   i_idValid           instruction present in ID
//   i_rsA, i_rsB        source registers, i_useImm masks i_rsB
//   i_exValid/WbEn/Load/Rd  instruction currently held in the EX registers
//   i_memRd/WbEn, i_wbRd/WbEn  downstream producers
//   o_idReady           stage accepts id_* this cycle
// ---------------------------------------------------------------------------
module hazard_unit
  import aluPkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_idValid,
  input  logic [4:0] i_rsA,
  input  logic [4:0] i_rsB,
  input  logic       i_useImm,
  input  logic       i_exValid,
  input  logic       i_exWbEn,
  input  logic       i_exLoad,
  input  logic [4:0] i_exRd,
  input  logic [4:0] i_memRd,
  input  logic       i_memWbEn,
  input  logic [4:0] i_wbRd,
  input  logic       i_wbWbEn,
  output logic       o_idReady
);

  stage_state_t r_state;

`ifdef ID_EX_FWD_EN

  logic w_loadUse;
  logic w_unused;

  // A load's data is not available to forward until it leaves MEM, so a
  // consumer directly behind it must wait.
  assign w_loadUse = i_exValid && i_exLoad && (i_exRd != 5'd0) &&
                     ((i_exRd == i_rsA) || (!i_useImm && (i_exRd == i_rsB)));

  assign o_idReady = !i_rst && (r_state == RUN) && !w_loadUse;

  assign w_unused = ^{i_exWbEn, i_memRd, i_memWbEn, i_wbRd, i_wbWbEn};

  // BUBBLE lasts one cycle; after it the load sits in WB and forwards.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= RUN;
    end else if ((r_state == RUN) && w_loadUse && i_idValid) begin
      r_state <= BUBBLE;
    end else begin
      r_state <= RUN;
    end
  end

`else

  logic [1:0] r_cnt;
  logic       w_hitA;
  logic       w_hitB;
  logic       w_raw;
  logic       w_stall;
  logic       w_unused;

  // Without forwarding, any in-flight writer of a source must retire first.
  assign w_hitA = (i_rsA != 5'd0) &&
                  ((i_exValid && i_exWbEn && (i_exRd == i_rsA)) ||
                   (i_memWbEn && (i_memRd == i_rsA)) ||
                   (i_wbWbEn && (i_wbRd == i_rsA)));
  assign w_hitB = (i_rsB != 5'd0) &&
                  ((i_exValid && i_exWbEn && (i_exRd == i_rsB)) ||
                   (i_memWbEn && (i_memRd == i_rsB)) ||
                   (i_wbWbEn && (i_wbRd == i_rsB)));
  assign w_raw  = i_idValid && (w_hitA || (!i_useImm && w_hitB));

  // Once the cap is reached the producer has written the register file,
  // so the instruction issues even if the match is still visible.
  assign w_stall   = w_raw && !((r_state == BUBBLE) && (r_cnt == MAX_RAW_BUBBLES));
  assign o_idReady = !i_rst && !w_stall;

  assign w_unused = i_exLoad;

  // r_cnt counts the bubbles already inserted for the waiting instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else if (w_stall) begin
      r_state <= BUBBLE;
      r_cnt   <= r_cnt + 2'd1;
    end else begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end
  end

`endif

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and hazard stalling.
// Build option: ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding with a
// one-cycle load-use bubble; without it operands come straight from the
// register file and RAW hazards stall.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_valid / id_ready              handshake with decode
//   id_rs_a, id_rs_b                 source register indices
//   id_rdata_a, id_rdata_b           register-file read data
//   id_imm, id_use_imm               immediate replaces operand B
//   id_op, id_rd, id_wb_en, id_load  opcode and sideband
//   flush                            kill the stage contents
//   mem_rd/wb_en/result              EX/MEM producer
//   wb_rd/wb_en/result               MEM/WB producer
//   ex_valid, ex_a, ex_b, ex_op, ex_rd, ex_wb_en, ex_load  registered outputs
// ---------------------------------------------------------------------------
module id_ex_stage
  import aluPkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  output logic         id_ready,
  input  logic [4:0]   id_rs_a,
  input  logic [4:0]   id_rs_b,
  input  logic [N-1:0] id_rdata_a,
  input  logic [N-1:0] id_rdata_b,
  input  logic [N-1:0] id_imm,
  input  logic         id_use_imm,
  input  logic [4:0]   id_op,
  input  logic [4:0]   id_rd,
  input  logic         id_wb_en,
  input  logic         id_load,
  input  logic         flush,
  input  logic [4:0]   mem_rd,
  input  logic         mem_wb_en,
  input  logic [N-1:0] mem_result,
  input  logic [4:0]   wb_rd,
  input  logic         wb_wb_en,
  input  logic [N-1:0] wb_result,
  output logic         ex_valid,
  output logic [N-1:0] ex_a,
  output logic [N-1:0] ex_b,
  output logic [4:0]   ex_op,
  output logic [4:0]   ex_rd,
  output logic         ex_wb_en,
  output logic         ex_load
);

  logic         w_idReady;
  logic [N-1:0] w_opA;
  logic [N-1:0] w_opB;

  logic         r_exValid;
  logic [N-1:0] r_exA;
  logic [N-1:0] r_exB;
  logic [4:0]   r_exOp;
  logic [4:0]   r_exRd;
  logic         r_exWbEn;
  logic         r_exLoad;

`ifdef ID_EX_FWD_EN

  fwd_sel_t     w_selA;
  fwd_sel_t     w_selB;
  logic [N-1:0] w_fwdB;

  assign w_selA = fwdSelect(id_rs_a, mem_rd, mem_wb_en, wb_rd, wb_wb_en);
  assign w_selB = fwdSelect(id_rs_b, mem_rd, mem_wb_en, wb_rd, wb_wb_en);

  // The immediate bypasses forwarding entirely for operand B.
  always_comb begin
    w_opA  = id_rdata_a;
    w_fwdB = id_rdata_b;
    case (w_selA)
      FWD_MEM: w_opA = mem_result;
      FWD_WB:  w_opA = wb_result;
      default: w_opA = id_rdata_a;
    endcase
    case (w_selB)
      FWD_MEM: w_fwdB = mem_result;
      FWD_WB:  w_fwdB = wb_result;
      default: w_fwdB = id_rdata_b;
    endcase
    w_opB = id_use_imm ? id_imm : w_fwdB;
  end

`else

  logic [N-1:0] w_unused;

  assign w_opA    = id_rdata_a;
  assign w_opB    = id_use_imm ? id_imm : id_rdata_b;
  assign w_unused = mem_result ^ wb_result;

`endif

  hazard_unit u_hazard (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_idValid (id_valid),
    .i_rsA     (id_rs_a),
    .i_rsB     (id_rs_b),
    .i_useImm  (id_use_imm),
    .i_exValid (r_exValid),
    .i_exWbEn  (r_exWbEn),
    .i_exLoad  (r_exLoad),
    .i_exRd    (r_exRd),
    .i_memRd   (mem_rd),
    .i_memWbEn (mem_wb_en),
    .i_wbRd    (wb_rd),
    .i_wbWbEn  (wb_wb_en),
    .o_idReady (w_idReady)
  );

  assign id_ready = w_idReady;

  // Flush, stall and an empty ID slot all load a bubble: only the flags
  // clear, the data fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exValid <= 1'b0;
      r_exA     <= '0;
      r_exB     <= '0;
      r_exOp    <= 5'd0;
      r_exRd    <= 5'd0;
      r_exWbEn  <= 1'b0;
      r_exLoad  <= 1'b0;
    end else if (id_valid && w_idReady && !flush) begin
      r_exValid <= 1'b1;
      r_exA     <= w_opA;
      r_exB     <= w_opB;
      r_exOp    <= id_op;
      r_exRd    <= id_rd;
      r_exWbEn  <= id_wb_en;
      r_exLoad  <= id_load;
    end else begin
      r_exValid <= 1'b0;
      r_exWbEn  <= 1'b0;
      r_exLoad  <= 1'b0;
    end
  end

  assign ex_valid = r_exValid;
  assign ex_a     = r_exA;
  assign ex_b     = r_exB;
  assign ex_op    = r_exOp;
  assign ex_rd    = r_exRd;
  assign ex_wb_en = r_exWbEn;
  assign ex_load  = r_exLoad;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage with a behavioural model of the stage.
// Works for both builds (ID_EX_FWD_EN defined or not).
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import aluPkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid;
  logic         id_ready;
  logic [4:0]   id_rs_a, id_rs_b;
  logic [N-1:0] id_rdata_a, id_rdata_b, id_imm;
  logic         id_use_imm;
  logic [4:0]   id_op, id_rd;
  logic         id_wb_en, id_load;
  logic         flush;
  logic [4:0]   mem_rd, wb_rd;
  logic         mem_wb_en, wb_wb_en;
  logic [N-1:0] mem_result, wb_result;
  logic         ex_valid, ex_wb_en, ex_load;
  logic [N-1:0] ex_a, ex_b;
  logic [4:0]   ex_op, ex_rd;

  id_ex_stage #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_op(id_op), .id_rd(id_rd), .id_wb_en(id_wb_en), .id_load(id_load),
    .flush(flush),
    .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_wb_en(wb_wb_en), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_load(ex_load)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;
  bit checking   = 1'b0;

  // Model of what the EX registers must hold.
  typedef struct {
    logic         valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   op;
    logic [4:0]   rd;
    logic         wb;
    logic         load;
  } exModel_t;

  exModel_t mEx;
  bit       mBubble = 1'b0;
  int       mStall  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Load-use: a valid load in EX writes a register the ID instruction reads.
  function automatic logic modelLoadUse();
    return mEx.valid && mEx.load && (mEx.rd != 5'd0) &&
           ((mEx.rd == id_rs_a) || (!id_use_imm && (mEx.rd == id_rs_b)));
  endfunction

  function automatic logic srcPending(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    return (mEx.valid && mEx.wb && (mEx.rd == rs)) ||
           (mem_wb_en && (mem_rd == rs)) || (wb_wb_en && (wb_rd == rs));
  endfunction

  function automatic logic modelHazard();
    return id_valid && (srcPending(id_rs_a) || (!id_use_imm && srcPending(id_rs_b)));
  endfunction

  function automatic logic modelReady();
    if (rst) return 1'b0;
`ifdef ID_EX_FWD_EN
    return !mBubble && !modelLoadUse();
`else
    return !(modelHazard() && (mStall < 3));
`endif
  endfunction

  function automatic logic [N-1:0] pick(input logic [4:0] rs, input logic [N-1:0] rf);
`ifdef ID_EX_FWD_EN
    if ((rs != 5'd0) && mem_wb_en && (mem_rd == rs)) return mem_result;
    if ((rs != 5'd0) && wb_wb_en && (wb_rd == rs)) return wb_result;
`endif
    return rf;
  endfunction

  // Advance the model on each rising edge from the inputs present there.
  always @(posedge clk) begin : modelUpdate
    logic rdy, lu, hz;
    rdy = modelReady();
    lu  = modelLoadUse();
    hz  = modelHazard();
    if (rst) begin
      mEx     = '{valid: 1'b0, a: '0, b: '0, op: 5'd0, rd: 5'd0, wb: 1'b0, load: 1'b0};
      mBubble = 1'b0;
      mStall  = 0;
    end else if (flush) begin
      mEx.valid = 1'b0; mEx.wb = 1'b0; mEx.load = 1'b0;
      mBubble   = 1'b0;
      mStall    = 0;
    end else begin
      if (id_valid && rdy) begin
        mEx.valid = 1'b1;
        mEx.a     = pick(id_rs_a, id_rdata_a);
        mEx.b     = id_use_imm ? id_imm : pick(id_rs_b, id_rdata_b);
        mEx.op    = id_op;
        mEx.rd    = id_rd;
        mEx.wb    = id_wb_en;
        mEx.load  = id_load;
      end else begin
        mEx.valid = 1'b0; mEx.wb = 1'b0; mEx.load = 1'b0;
      end
      mBubble = !mBubble && lu && id_valid;
      mStall  = (hz && (mStall < 3)) ? mStall + 1 : 0;
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc id_ready", id_ready, modelReady());
      checkOutput("cyc ex_valid", ex_valid, mEx.valid);
      checkOutput("cyc ex_a", ex_a, mEx.a);
      checkOutput("cyc ex_b", ex_b, mEx.b);
      checkOutput("cyc ex_op", ex_op, mEx.op);
      checkOutput("cyc ex_rd", ex_rd, mEx.rd);
      checkOutput("cyc ex_wb_en", ex_wb_en, mEx.wb);
      checkOutput("cyc ex_load", ex_load, mEx.load);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rsA, input logic [4:0] rsB,
                               input logic [N-1:0] rdA, input logic [N-1:0] rdB,
                               input logic [N-1:0] imm, input logic useImm,
                               input logic [4:0] op, input logic [4:0] rd,
                               input logic wb, input logic load);
    id_valid = valid; id_rs_a = rsA; id_rs_b = rsB;
    id_rdata_a = rdA; id_rdata_b = rdB; id_imm = imm; id_use_imm = useImm;
    id_op = op; id_rd = rd; id_wb_en = wb; id_load = load;
  endtask

  task automatic setProducers(input logic [4:0] mRd, input logic mWb, input logic [N-1:0] mRes,
                              input logic [4:0] wRd, input logic wWb, input logic [N-1:0] wRes);
    mem_rd = mRd; mem_wb_en = mWb; mem_result = mRes;
    wb_rd = wRd; wb_wb_en = wWb; wb_result = wRes;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    applyStimulus(1, 5'd1, 5'd2, 32'd9, 32'd9, 32'd0, 0, ALU_ADD, 5'd3, 1, 0);
    setProducers(5'd0, 0, '0, 5'd0, 0, '0);
    tick();
    checking = 1'b1;
    checkOutput("rst id_ready", id_ready, 1'b0);
    checkOutput("rst ex_valid", ex_valid, 1'b0);
    checkOutput("rst ex_a", ex_a, 32'd0);
    checkOutput("rst ex_op", ex_op, 5'd0);
    rst = 1'b0;

    // Plain ADD, no producers.
    applyStimulus(1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 0, ALU_ADD, 5'd6, 1, 0);
    tick();
    checkOutput("add ex_a", ex_a, 32'd5);
    checkOutput("add ex_b", ex_b, 32'd7);
    checkOutput("add ex_op", ex_op, 5'd1);
    checkOutput("add ex_valid", ex_valid, 1'b1);
    checkOutput("add ex_rd", ex_rd, 5'd6);

    // Empty ID slot: bubble holds data.
    id_valid = 1'b0;
    tick();
    checkOutput("idle ex_valid", ex_valid, 1'b0);
    checkOutput("idle holds ex_a", ex_a, 32'd5);
    checkOutput("idle holds ex_op", ex_op, 5'd1);

    // Register 0 never forwards.
    setProducers(5'd0, 1, 32'h99, 5'd0, 0, '0);
    applyStimulus(1, 5'd0, 5'd9, 32'd0, 32'h33, 32'd0, 0, ALU_OR, 5'd10, 1, 0);
    tick();
    checkOutput("r0 ex_a", ex_a, 32'd0);
    checkOutput("r0 ex_b", ex_b, 32'h33);

    // Both producers match rs_a.
    setProducers(5'd3, 1, 32'h11, 5'd3, 1, 32'h22);
    applyStimulus(1, 5'd3, 5'd8, 32'h44, 32'd0, 32'h1234, 1, ALU_ADD, 5'd11, 1, 0);
`ifdef ID_EX_FWD_EN
    tick();
    checkOutput("prio ex_a", ex_a, 32'h11);
    checkOutput("prio ex_b imm", ex_b, 32'h1234);
`else
    #1 checkOutput("raw stall ready", id_ready, 1'b0);
    repeat (3) tick();
    #1 checkOutput("raw cap ready", id_ready, 1'b1);
    tick();
    checkOutput("raw ex_a", ex_a, 32'h44);
    checkOutput("raw ex_b imm", ex_b, 32'h1234);
`endif

    // Load followed by a dependent instruction on operand B.
    setProducers(5'd0, 0, '0, 5'd0, 0, '0);
    applyStimulus(1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, ALU_ADD, 5'd4, 1, 1);
    tick();
    checkOutput("load ex_load", ex_load, 1'b1);
    checkOutput("load ex_rd", ex_rd, 5'd4);
    applyStimulus(1, 5'd0, 5'd4, 32'd0, 32'h55, 32'd0, 0, ALU_SUB, 5'd7, 1, 0);
    #1 checkOutput("lu ready", id_ready, 1'b0);
    tick();
    checkOutput("lu bubble", ex_valid, 1'b0);
    setProducers(5'd4, 1, 32'h66, 5'd0, 0, '0);
    #1 checkOutput("lu bubble ready", id_ready, 1'b0);
    tick();
    setProducers(5'd0, 0, '0, 5'd4, 1, 32'h77);
`ifdef ID_EX_FWD_EN
    #1 checkOutput("lu resume ready", id_ready, 1'b1);
    tick();
    checkOutput("lu ex_b wb fwd", ex_b, 32'h77);
`else
    #1 checkOutput("lu third stall", id_ready, 1'b0);
    tick();
    #1 checkOutput("lu resume ready", id_ready, 1'b1);
    tick();
    checkOutput("lu ex_b rf", ex_b, 32'h55);
`endif
    checkOutput("lu ex_valid", ex_valid, 1'b1);

    // Flush while stalled.
    setProducers(5'd0, 0, '0, 5'd0, 0, '0);
    applyStimulus(1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, ALU_ADD, 5'd5, 1, 1);
    tick();
    applyStimulus(1, 5'd5, 5'd0, 32'hA5, 32'd0, 32'd0, 0, ALU_XOR, 5'd12, 1, 0);
    #1 checkOutput("fl stall ready", id_ready, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl ex_valid", ex_valid, 1'b0);
    #1 checkOutput("fl ready", id_ready, 1'b1);
    tick();
    checkOutput("fl reissue valid", ex_valid, 1'b1);
    checkOutput("fl reissue ex_a", ex_a, 32'hA5);

    // Reset during traffic.
    applyStimulus(1, 5'd1, 5'd2, 32'h10, 32'h20, 32'd0, 0, ALU_AND, 5'd13, 1, 0);
    tick();
    checkOutput("pre-rst valid", ex_valid, 1'b1);
    rst = 1'b1;
    #1 checkOutput("rst high ready", id_ready, 1'b0);
    tick();
    checkOutput("rst2 ex_valid", ex_valid, 1'b0);
    checkOutput("rst2 ex_a", ex_a, 32'd0);
    checkOutput("rst2 ex_b", ex_b, 32'd0);
    checkOutput("rst2 ex_op", ex_op, 5'd0);
    checkOutput("rst2 ex_rd", ex_rd, 5'd0);
    checkOutput("rst2 ex_wb_en", ex_wb_en, 1'b0);
    rst = 1'b0;
    #1 checkOutput("post-rst ready", id_ready, 1'b1);

    // Mixed traffic on a few registers, checked by the model each cycle.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 10)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0));
      setProducers(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    flush = 1'b0;
    id_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
